fetch_buffer: RTL and testbench

FETCH_BUFFER -- requirements
Module: fetch_buffer

---
 rtl/fetch_pkg.sv | 19 +
 rtl/fetch_fifo.sv | 70 +++++++
 rtl/fetch_buffer.sv | 87 ++++++++
 tb/tb_fetch_buffer.sv | 238 +++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch buffer: widths, default sizing,
// the buffered entry layout and the sequential PC step helper.
package fetch_pkg;

  localparam int XLEN    = 32;
  localparam int DEPTH   = 2;
  localparam int PC_STEP = 4;

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] instr;
  } fetch_entry_t;

  // Sequential PC increment; wraps modulo 2^XLEN.
  function automatic logic [XLEN-1:0] pc_step(input logic [XLEN-1:0] pc, input int step);
    return pc + XLEN'(step);
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer storage: DEPTH entries of {pc, instr} with wrapping
// pointers, an occupancy count and a synchronous clear used on redirect.
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int DEPTH = fetch_pkg::DEPTH
) (
  input  logic                   clk,
  input  logic                   clr,
  input  logic                   clear,
  input  logic                   push,
  input  fetch_entry_t           push_data,
  input  logic                   pop,
  output fetch_entry_t           head,
  output logic [$clog2(DEPTH):0] count,
  output logic                   empty
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0] wr_ptr_reg;
  logic [AW-1:0] rd_ptr_reg;
  logic [CW-1:0] count_reg;
  fetch_entry_t  entries [DEPTH];

  // One register per slot so every entry can be cleared by the async reset.
  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_slot
    fetch_entry_t entry_reg;

    always_ff @(posedge clk or negedge clr) begin
      if (!clr) begin
        entry_reg <= '0;
      end else if (push && !clear && (wr_ptr_reg == AW'(gi))) begin
        entry_reg <= push_data;
      end
    end

    assign entries[gi] = entry_reg;
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (clear) begin
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + AW'(1);
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + AW'(1);
      end
      case ({push, pop})
        2'b10:   count_reg <= count_reg + CW'(1);
        2'b01:   count_reg <= count_reg - CW'(1);
        default: count_reg <= count_reg;
      endcase
    end
  end

  assign head  = entries[rd_ptr_reg];
  assign count = count_reg;
  assign empty = (count_reg == '0);

endmodule

// File: rtl/fetch_buffer.sv
// Fetch front end: drives the PC register and instruction memory, tracks one
// in-flight read and only issues when a buffer slot is guaranteed free.
module fetch_buffer
  import fetch_pkg::*;
#(
  parameter int DEPTH   = fetch_pkg::DEPTH,
  parameter int PC_STEP = fetch_pkg::PC_STEP
) (
  input  logic            clk,
  input  logic            clr,
  input  logic [XLEN-1:0] pc_in,
  output logic            pc_load,
  output logic [XLEN-1:0] pc_next,
  output logic            imem_en,
  input  logic [XLEN-1:0] imem_rdata,
  input  logic            redirect,
  input  logic [XLEN-1:0] redirect_pc,
  input  logic            id_stall,
  output logic            id_valid,
  output logic [XLEN-1:0] id_instr,
  output logic [XLEN-1:0] id_pc
);

  localparam int          CW      = $clog2(DEPTH) + 1;
  localparam logic [CW:0] DEPTH_W = (CW + 1)'(DEPTH);

  logic            inflight_reg;
  logic [XLEN-1:0] inflight_pc_reg;

  logic [CW-1:0]   count;
  logic            empty;
  fetch_entry_t    head;
  fetch_entry_t    push_entry;
  logic            push;
  logic            pop;
  logic            issue;
  logic [CW:0]     credit_used;

  assign pop  = !empty && !id_stall && !redirect;
  assign push = inflight_reg && !redirect;

  // Slots committed after this edge: buffered entries, minus the one leaving,
  // plus the read already on its way back from memory.
  assign credit_used = {1'b0, count} + {{CW{1'b0}}, inflight_reg} - {{CW{1'b0}}, pop};
  assign issue       = clr && !redirect && (credit_used < DEPTH_W);

  assign imem_en = issue;
  assign pc_load = issue || (clr && redirect);
  assign pc_next = redirect ? redirect_pc : pc_step(pc_in, PC_STEP);

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      inflight_reg    <= 1'b0;
      inflight_pc_reg <= '0;
    end else begin
      inflight_reg <= issue;
      if (issue) begin
        inflight_pc_reg <= pc_in;
      end
    end
  end

  always_comb begin
    push_entry       = '0;
    push_entry.pc    = inflight_pc_reg;
    push_entry.instr = imem_rdata;
  end

  fetch_fifo #(
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk      (clk),
    .clr      (clr),
    .clear    (redirect),
    .push     (push),
    .push_data(push_entry),
    .pop      (pop),
    .head     (head),
    .count    (count),
    .empty    (empty)
  );

  assign id_valid = !empty;
  assign id_instr = empty ? '0 : head.instr;
  assign id_pc    = empty ? '0 : head.pc;

endmodule

// File: tb/tb_fetch_buffer.sv
// Self-checking bench for fetch_buffer with a PC register and instruction
// memory model; delivered instructions are scored against an expected-PC queue.
module tb_fetch_buffer;
  import fetch_pkg::*;

  logic        clk = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] pc_in;
  logic        pc_load;
  logic [31:0] pc_next;
  logic        imem_en;
  logic [31:0] imem_rdata;
  logic        redirect = 1'b0;
  logic [31:0] redirect_pc = 32'h0;
  logic        id_stall = 1'b0;
  logic        id_valid;
  logic [31:0] id_instr;
  logic [31:0] id_pc;

  logic [31:0] pc_reg;
  logic [31:0] exp_q[$];
  logic [31:0] mon_pc;
  int          checks = 0;
  int          passes = 0;

  always #5 clk = ~clk;

  fetch_buffer dut (
    .clk        (clk),
    .clr        (clr),
    .pc_in      (pc_in),
    .pc_load    (pc_load),
    .pc_next    (pc_next),
    .imem_en    (imem_en),
    .imem_rdata (imem_rdata),
    .redirect   (redirect),
    .redirect_pc(redirect_pc),
    .id_stall   (id_stall),
    .id_valid   (id_valid),
    .id_instr   (id_instr),
    .id_pc      (id_pc)
  );

  function automatic logic [31:0] instr_of(input logic [31:0] pc);
    return ((pc >> 2) + 32'd1) * 32'h11;
  endfunction

  // PC register and instruction memory models.
  always_ff @(posedge clk or negedge clr) begin
    if (!clr) pc_reg <= 32'h0;
    else if (pc_load) pc_reg <= pc_next;
  end
  assign pc_in = pc_reg;

  always_ff @(posedge clk) begin
    imem_rdata <= imem_en ? instr_of(pc_in) : 32'hDEAD_BEEF;
  end

  // Scoreboard: every accepted instruction must be the next expected PC.
  always @(negedge clk) begin
    if (id_valid && !id_stall && !redirect) begin
      checks++;
      if (exp_q.size() == 0) begin
        $display("FAIL extra_delivery got pc=%h instr=%h expected none", id_pc, id_instr);
      end else begin
        mon_pc = exp_q.pop_front();
        if (id_pc !== mon_pc || id_instr !== instr_of(mon_pc))
          $display("FAIL deliver got pc=%h instr=%h expected pc=%h instr=%h",
                   id_pc, id_instr, mon_pc, instr_of(mon_pc));
        else begin
          passes++;
          $display("deliver pc=%h instr=%h", id_pc, id_instr);
        end
      end
    end
  end

  task automatic push_stream(input logic [31:0] start, input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(start + 32'(i * PC_STEP));
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    clr = 1'b0; id_stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
    exp_q.delete();
    @(posedge clk);
    #1 clr = 1'b1;
  endtask

  // Wait (bounded) until the scoreboard empties, then freeze delivery.
  task automatic drain(input string name);
    for (int i = 0; i < 60 && exp_q.size() != 0; i++) @(posedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) $display("FAIL %s_drain got %0d pending expected 0", name, exp_q.size());
    else passes++;
    id_stall = 1'b1;
  endtask

  task automatic test_reset();
    @(posedge clk);
    #1 clr = 1'b0;
    #2;
    checks++; if (id_valid !== 1'b0) $display("FAIL reset_id_valid got=%b expected=0", id_valid); else passes++;
    checks++; if (id_pc !== 32'h0) $display("FAIL reset_id_pc got=%h expected=0", id_pc); else passes++;
    checks++; if (id_instr !== 32'h0) $display("FAIL reset_id_instr got=%h expected=0", id_instr); else passes++;
    checks++; if (imem_en !== 1'b0) $display("FAIL reset_imem_en got=%b expected=0", imem_en); else passes++;
    checks++; if (pc_load !== 1'b0) $display("FAIL reset_pc_load got=%b expected=0", pc_load); else passes++;
    @(posedge clk);
    #1 clr = 1'b1;
    @(negedge clk);
    checks++; if (imem_en !== 1'b1) $display("FAIL release_imem_en got=%b expected=1", imem_en); else passes++;
    checks++; if (pc_in !== 32'h0) $display("FAIL release_pc_in got=%h expected=0", pc_in); else passes++;
    checks++; if (pc_next !== 32'(PC_STEP)) $display("FAIL release_pc_next got=%h expected=%h", pc_next, 32'(PC_STEP)); else passes++;
  endtask

  task automatic test_fill();
    do_reset();
    push_stream(32'h0, 8);
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) $display("FAIL fill_c0_valid got=%b expected=0", id_valid); else passes++;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) $display("FAIL fill_c1_valid got=%b expected=0", id_valid); else passes++;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1) $display("FAIL fill_c2_valid got=%b expected=1", id_valid); else passes++;
    checks++; if (id_instr !== 32'h11) $display("FAIL fill_c2_instr got=%h expected=00000011", id_instr); else passes++;
    // Remaining 7 must arrive on the next 7 consecutive cycles.
    repeat (8) @(posedge clk);
    #1;
    checks++; if (exp_q.size() != 0) $display("FAIL fill_throughput got %0d pending expected 0", exp_q.size()); else passes++;
    id_stall = 1'b1;
  endtask

  task automatic test_stall();
    logic [31:0] held_pc;
    do_reset();
    push_stream(32'h0, 10);
    repeat (3) @(posedge clk);
    #1 id_stall = 1'b1;
    repeat (4) @(negedge clk);
    checks++; if (imem_en !== 1'b0) $display("FAIL stall_imem_en got=%b expected=0", imem_en); else passes++;
    checks++; if (pc_load !== 1'b0) $display("FAIL stall_pc_load got=%b expected=0", pc_load); else passes++;
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4) $display("FAIL stall_head got valid=%b pc=%h expected valid=1 pc=4", id_valid, id_pc); else passes++;
    held_pc = pc_in;
    checks++; if (held_pc !== 32'hC) $display("FAIL stall_pc_in got=%h expected=0000000c", held_pc); else passes++;
    repeat (2) @(negedge clk);
    checks++; if (pc_in !== 32'hC) $display("FAIL stall_pc_frozen got=%h expected=0000000c", pc_in); else passes++;
    @(posedge clk);
    #1 id_stall = 1'b0;
    drain("stall");
  endtask

  task automatic test_redirect_full();
    do_reset();
    push_stream(32'h0, 10);
    repeat (3) @(posedge clk);
    #1 id_stall = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h100;
    exp_q.delete();
    push_stream(32'h100, 6);
    @(posedge clk);
    #1 redirect = 1'b0; id_stall = 1'b0;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) $display("FAIL redir_r1_valid got=%b expected=0", id_valid); else passes++;
    checks++; if (pc_in !== 32'h100) $display("FAIL redir_r1_pc_in got=%h expected=00000100", pc_in); else passes++;
    @(negedge clk);
    checks++; if (id_valid !== 1'b0) $display("FAIL redir_r2_valid got=%b expected=0", id_valid); else passes++;
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h100) $display("FAIL redir_r3_head got valid=%b pc=%h expected valid=1 pc=00000100", id_valid, id_pc); else passes++;
    drain("redir_full");
  endtask

  task automatic test_redirect_pop();
    do_reset();
    push_stream(32'h0, 1);
    repeat (3) @(posedge clk);
    #1;
    redirect = 1'b1; redirect_pc = 32'h100;
    exp_q.delete();
    push_stream(32'h100, 6);
    @(negedge clk);
    checks++; if (id_valid !== 1'b1 || id_pc !== 32'h4) $display("FAIL rpop_head got valid=%b pc=%h expected valid=1 pc=4", id_valid, id_pc); else passes++;
    checks++; if (imem_en !== 1'b0) $display("FAIL rpop_imem_en got=%b expected=0", imem_en); else passes++;
    checks++; if (pc_load !== 1'b1 || pc_next !== 32'h100) $display("FAIL rpop_pc got load=%b next=%h expected load=1 next=00000100", pc_load, pc_next); else passes++;
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    checks++; if (pc_in !== 32'h100) $display("FAIL rpop_pc_in got=%h expected=00000100", pc_in); else passes++;
    drain("redir_pop");
  endtask

  task automatic test_wrap();
    do_reset();
    redirect = 1'b1; redirect_pc = 32'hFFFF_FFFC;
    push_stream(32'hFFFF_FFFC, 4);
    @(posedge clk);
    #1 redirect = 1'b0;
    @(negedge clk);
    checks++; if (pc_in !== 32'hFFFF_FFFC) $display("FAIL wrap_pc_in got=%h expected=fffffffc", pc_in); else passes++;
    checks++; if (pc_next !== 32'h0) $display("FAIL wrap_pc_next got=%h expected=00000000", pc_next); else passes++;
    drain("wrap");
  endtask

  task automatic test_async_reset();
    do_reset();
    push_stream(32'h0, 10);
    repeat (4) @(posedge clk);
    #2 clr = 1'b0;
    exp_q.delete();
    #1;
    checks++; if (id_valid !== 1'b0 || id_pc !== 32'h0 || id_instr !== 32'h0)
      $display("FAIL areset_outputs got valid=%b pc=%h instr=%h expected all 0", id_valid, id_pc, id_instr);
    else passes++;
    checks++; if (imem_en !== 1'b0 || pc_load !== 1'b0) $display("FAIL areset_fetch got en=%b load=%b expected 0 0", imem_en, pc_load); else passes++;
    #1 clr = 1'b1;
    push_stream(32'h0, 6);
    @(negedge clk);
    checks++; if (imem_en !== 1'b1 || pc_in !== 32'h0) $display("FAIL areset_refetch got en=%b pc_in=%h expected en=1 pc_in=0", imem_en, pc_in); else passes++;
    drain("areset");
  endtask

  initial begin
    test_reset();
    test_fill();
    test_stall();
    test_redirect_full();
    test_redirect_pop();
    test_wrap();
    test_async_reset();
    repeat (2) @(posedge clk);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
